// File: rtl/mem_req_initiator.sv
// Burst memory-request initiator: turns host read/write burst commands into
// return-to-zero single-word target accesses. Define MEM_REQ_TIMEOUT_EN for the REQ watchdog.
module mem_req_initiator #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 512,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [DATA_WIDTH-1:0] wdat_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WFETCH, REQ, RESP} state_e;

  localparam int                  WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WD_W-1:0]     WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef MEM_REQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    last_q, last_d;
  logic [8:0]              beats_q, beats_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic                    err_q, err_d;
  logic                    timeout_hit;
  logic [ADDR_WIDTH-1:0]   addr_next;

  assign addr_next   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (state_q == REQ) && !mem_ready && (wdog_q == WD_LAST);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    beats_d = beats_q;
    wdog_d  = '0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if ({1'b0, cmd_addr} >= DEPTH_EXT) begin
            err_d = 1'b1;
          end else begin
            write_d = cmd_write;
            addr_d  = cmd_addr;
            beats_d = {1'b0, cmd_len} + 9'd1;
            state_d = cmd_write ? WFETCH : REQ;
          end
        end
      end
      WFETCH: begin
        if (wdat_valid) begin
          wdata_d = wdat_data;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          beats_d = beats_q - 9'd1;
          addr_d  = addr_next;
          if (write_q) begin
            state_d = (beats_q == 9'd1) ? IDLE : WFETCH;
          end else begin
            rdata_d = mem_rdata;
            last_d  = (beats_q == 9'd1);
            state_d = RESP;
          end
        end else if (timeout_hit) begin
          // Stalled target: drop the rest of the burst without producing responses.
          beats_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = (wdog_q == WD_LAST) ? wdog_q : wdog_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = (beats_q == 9'd0) ? IDLE : REQ;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b0;
      beats_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign wdat_ready = (state_q == WFETCH);
  assign mem_req    = (state_q == REQ);
  assign mem_we     = (state_q == REQ) && write_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_last   = (state_q == RESP) && last_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp_data   = rdata_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: table of directed bursts plus
// hand-written sequences for response back-pressure, watchdog and mid-burst reset.
module tb_mem_req_initiator;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wdat_valid, wdat_ready;
  logic [DW-1:0] wdat_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, err;

  mem_req_initiator #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic write; logic [AW-1:0] addr; logic [7:0] len; logic exp_err; } vec_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } acc_t;
  typedef struct { logic [DW-1:0] data; logic last; } rsp_t;

  int checks = 0;
  int errors = 0;
  int rtz_err = 0, lat_err = 0, req_seen = 0, rsp_seen = 0;
  logic mem_en = 1'b1, rsp_en = 1'b1;
  logic req_prev = 1'b0, rd_hs_prev = 1'b0, wr_hs_prev = 1'b0, wd_hs_prev = 1'b0;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [DW-1:0] wq[$];
  vec_t vecs[7];

  localparam logic [51:0] RST_VEC = {8'b1000_0000, 44'h0};

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return {4'hD, a} ^ 16'h0F0F;
  endfunction

  function automatic logic [DW-1:0] wd(input int k);
    case (k)
      0:       return 16'hA5A5;
      1:       return 16'h5A5A;
      2:       return 16'h1234;
      default: return 16'h1000 + 16'(k);
    endcase
  endfunction

  function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [51:0] outs();
    return {cmd_ready, wdat_ready, rsp_valid, rsp_last, mem_req, mem_we, busy, err,
            mem_addr, mem_wdata, rsp_data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issued at posedge+1 of cycle N; returns at posedge+1 of cycle N+1.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    check("cmd_ready_idle", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 200 && busy; c++) next_cycle();
    check({name, "_idle_wait"}, busy, 0);
  endtask

  // Target and host model: decides handshake inputs for the coming edge and
  // records the handshakes it grants.
  initial begin
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    rsp_ready  = 1'b0;
    wdat_valid = 1'b0;
    wdat_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((rd_hs_prev && !rsp_valid) || (wd_hs_prev && !mem_req)) lat_err++;
        if ((rd_hs_prev || wr_hs_prev) && mem_req) rtz_err++;
      end
      if (mem_req) req_seen++;
      if (rsp_valid) rsp_seen++;
      mem_ready  = mem_en && mem_req && req_prev;
      mem_rdata  = mem_ready ? rd_model(mem_addr) : '0;
      rd_hs_prev = mem_req && mem_ready && !mem_we;
      wr_hs_prev = mem_req && mem_ready && mem_we;
      if (mem_req && mem_ready) acc_q.push_back('{mem_addr, mem_we, mem_wdata});
      rsp_ready = rsp_en;
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_last});
      wdat_valid = (wq.size() != 0);
      wdat_data  = wdat_valid ? wq[0] : '0;
      wd_hs_prev = wdat_valid && wdat_ready;
      if (wd_hs_prev) void'(wq.pop_front());
      req_prev = mem_req;
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    logic [AW-1:0] a;
    string p;
    p = $sformatf("v%0d", idx);
    n = v.exp_err ? 0 : int'(v.len) + 1;
    acc_q.delete();
    rsp_q.delete();
    if (v.write && !v.exp_err) for (int k = 0; k < n; k++) wq.push_back(wd(k));
    issue(v.write, v.addr, v.len);
    if (v.exp_err) begin
      check({p, "_bad_addr_pulse"}, {err, mem_req, busy}, 3'b100);
      next_cycle();
      check({p, "_err_one_cycle"}, {err, mem_req, busy}, 3'b000);
    end else if (v.write) begin
      check({p, "_wr_wfetch"}, {wdat_ready, busy, mem_req}, 3'b110);
    end else begin
      check({p, "_rd_latency"}, {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, v.addr});
    end
    wait_idle(p);
    check({p, "_n_acc"}, acc_q.size(), n);
    a = v.addr;
    for (int i = 0; i < n && i < acc_q.size(); i++) begin
      check($sformatf("%s_acc%0d_addr", p, i), acc_q[i].addr, a);
      check($sformatf("%s_acc%0d_we", p, i), acc_q[i].we, v.write);
      if (v.write) check($sformatf("%s_acc%0d_wdata", p, i), acc_q[i].wdata, wd(i));
      a = inc_addr(a);
    end
    check({p, "_n_rsp"}, rsp_q.size(), v.write ? 0 : n);
    a = v.addr;
    for (int i = 0; i < n && i < rsp_q.size() && !v.write; i++) begin
      check($sformatf("%s_rsp%0d", p, i), {rsp_q[i].last, rsp_q[i].data},
            {(i == n - 1), rd_model(a)});
      a = inc_addr(a);
    end
  endtask

  initial begin
    logic [DW-1:0] d0;
    int stable, hi, dreq, drsp;

    vecs[0] = '{1'b0, 12'h010, 8'd3, 1'b0};
    vecs[1] = '{1'b1, 12'h1FE, 8'd2, 1'b0};
    vecs[2] = '{1'b0, 12'h1FF, 8'd1, 1'b0};
    vecs[3] = '{1'b0, 12'h200, 8'd0, 1'b1};
    vecs[4] = '{1'b1, 12'hFFF, 8'd4, 1'b1};
    vecs[5] = '{1'b1, 12'h000, 8'd0, 1'b0};
    vecs[6] = '{1'b0, 12'h1FD, 8'd5, 1'b0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (2) next_cycle();
    check("reset_outputs", outs(), RST_VEC);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Response back-pressure: rsp_data held, no new access, new commands ignored.
    acc_q.delete();
    rsp_q.delete();
    rsp_en = 1'b0;
    issue(1'b0, 12'h100, 8'd1);
    for (int c = 0; c < 20 && !rsp_valid; c++) next_cycle();
    check("hold_rsp_valid", rsp_valid, 1);
    d0 = rsp_data;
    check("hold_rsp_data", d0, rd_model(12'h100));
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h020;
    check("busy_cmd_ready", cmd_ready, 0);
    stable = 0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (rsp_valid && !mem_req && rsp_data == d0) stable++;
    end
    cmd_valid = 1'b0;
    check("hold_stable_cycles", stable, 5);
    rsp_en = 1'b1;
    wait_idle("hold");
    check("hold_accesses", {acc_q.size(), acc_q[0].addr, acc_q[1].addr, acc_q[1].we},
          {32'd2, 12'h100, 12'h101, 1'b0});
    check("hold_rsp_count", rsp_q.size(), 2);

    // Stalled target.
    acc_q.delete();
    rsp_q.delete();
    mem_en = 1'b0;
    issue(1'b0, 12'h005, 8'd0);
    hi = 0;
`ifdef MEM_REQ_TIMEOUT_EN
    while (mem_req && hi < 20) begin
      hi++;
      next_cycle();
    end
    check("wdog_req_cycles", hi, 8);
    check("wdog_err_idle", {err, busy, mem_req}, 3'b100);
    next_cycle();
    check("wdog_err_one_cycle", err, 0);
    mem_en = 1'b1;
    repeat (3) next_cycle();
    check("wdog_no_rsp", {rsp_q.size(), acc_q.size()}, 64'd0);
`else
    for (int c = 0; c < 20; c++) begin
      if (mem_req && !err) hi++;
      next_cycle();
    end
    check("stall_req_held", hi, 20);
    mem_en = 1'b1;
    wait_idle("stall");
    check("stall_rsp", {rsp_q.size(), rsp_q[0].data}, {32'd1, rd_model(12'h005)});
`endif

    // Reset in the middle of a 4-beat read.
    rsp_q.delete();
    issue(1'b0, 12'h040, 8'd3);
    for (int c = 0; c < 100 && rsp_q.size() < 1; c++) next_cycle();
    check("mid_reset_reached_beat2", rsp_q.size(), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", outs(), RST_VEC);
    repeat (2) next_cycle();
    reset = 1'b0;
    dreq  = req_seen;
    drsp  = rsp_seen;
    repeat (10) next_cycle();
    check("post_reset_quiet", {req_seen - dreq, rsp_seen - drsp}, 64'd0);

    check("return_to_zero", rtz_err, 0);
    check("handshake_latency", lat_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_req_initiator.md
MEM_REQ_INITIATOR -- requirements
Module: mem_req_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 16, data word width.
REQ-002 Parameter ADDR_WIDTH, default 12, address width.
REQ-003 Parameter DEPTH, default 512, number of valid words at target; legal addresses are 0..DEPTH-1.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only with MEM_REQ_TIMEOUT_EN).
REQ-005 Port list, in order:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  8  beats minus one (1..256 beats).
- wdat_valid  in  1  write word valid.
- wdat_ready  out  1  write word accepted.
- wdat_data  in  DATA_WIDTH  write word.
- rsp_valid  out  1  read word valid.
- rsp_ready  in  1  host accepts read word.
- rsp_data  out  DATA_WIDTH  read word.
- rsp_last  out  1  final beat of read burst.
- mem_req  out  1  target access request.
- mem_we  out  1  1=write access.
- mem_addr  out  ADDR_WIDTH  target address, drives target addr.
- mem_wdata  out  DATA_WIDTH  drives target data_in.
- mem_rdata  in  DATA_WIDTH  from target data_out.
- mem_ready  in  1  from target ready; access completes on mem_req && mem_ready.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle error pulse.

Function
REQ-006 States: IDLE, WFETCH, REQ, RESP.
REQ-007 IDLE: cmd_ready=1. On cmd_valid, latch cmd_write, cmd_addr, and beat count cmd_len+1. Go to WFETCH if write, REQ if read.
REQ-008 Bad address: if cmd_addr >= DEPTH, the command is accepted and err pulses the next cycle. No mem_req is issued and the state stays IDLE.
REQ-009 WFETCH: wdat_ready=1. On wdat_valid, capture wdat_data into mem_wdata and go to REQ.
REQ-010 REQ: mem_req=1 and mem_we=write flag. mem_addr and mem_wdata are held stable until the handshake cycle.
REQ-011 Write handshake:
- mem_ready high in REQ completes the beat.
- If beats remain, go to WFETCH; otherwise go to IDLE.
REQ-012 Read handshake:
- mem_ready high in REQ registers mem_rdata into rsp_data and goes to RESP.
- rsp_last=1 when the beat count is 1.
REQ-013 RESP: rsp_valid=1 and rsp_data is held. On rsp_ready, go to REQ if beats remain, otherwise to IDLE.
REQ-014 mem_req is low for at least one cycle between consecutive beats (return-to-zero).
REQ-015 Latency:
- Read: command accepted in cycle N gives mem_req high in cycle N+1. mem_ready in cycle M gives rsp_valid in cycle M+1.
- Write: wdat accepted in cycle N gives mem_req high in cycle N+1.
REQ-016 Address wrap: after each beat, mem_addr increments by 1; when it equals DEPTH-1 it wraps to 0. Arithmetic is ADDR_WIDTH bits.
REQ-017 The beat counter decrements once per completed beat. The burst ends exactly when the counter reaches 0.
REQ-018 cmd_valid outside IDLE is ignored: cmd_ready=0 and no command is latched.
REQ-019 mem_ready while mem_req=0 is ignored.

Reset
REQ-020 Asynchronous assertion forces:
- state to IDLE;
- mem_req, mem_we, wdat_ready, rsp_valid, rsp_last, busy, err to 0;
- mem_addr, mem_wdata, rsp_data, beat counter, watchdog to 0;
- cmd_ready to 1.
REQ-021 Reset mid-burst abandons the burst. No further mem_req or rsp_valid is produced until a new command is accepted.

Configuration
REQ-022 With MEM_REQ_TIMEOUT_EN defined, a watchdog counts consecutive REQ cycles with mem_ready=0. On reaching TIMEOUT_CYCLES:
- mem_req drops;
- err pulses one cycle;
- remaining beats are discarded with no rsp_valid;
- state goes to IDLE.
REQ-023 Without MEM_REQ_TIMEOUT_EN, REQ waits indefinitely for mem_ready, and err signals bad addresses only.

Verification
REQ-024 Read, cmd_addr=0x010, cmd_len=3, mem_ready one cycle after each mem_req -> mem_addr 0x010..0x013; 4 rsp_valid beats; rsp_last only on the 4th.
REQ-025 Write, cmd_addr=0x1FE, cmd_len=2, wdat 0xA5A5/0x5A5A/0x1234 -> mem_addr 0x1FE, 0x1FF, 0x000 with matching mem_wdata and mem_we=1.
REQ-026 Read with rsp_ready low for 5 cycles -> rsp_data held stable and no second mem_req until rsp_ready=1.
REQ-027 cmd_addr=0x200 (DEPTH=512) -> err high for one cycle, no mem_req, busy stays 0.
REQ-028 Reset asserted mid-read on beat 2 of 4 -> all outputs at reset values immediately; no rsp_valid after release.
REQ-029 With MEM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0 -> mem_req drops after 8 cycles, err pulses, then IDLE.
